// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Mode select values for the sub input
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Index counter width: must hold 0..width so the count never wraps
  function automatic int idx_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// 1-bit full-adder cell used by the serial datapath.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic Sum,
  output logic C_out
);

  assign Sum   = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per
// clock, LSB first. Results are published only when the last bit is done,
// so Sum never shows partial shifting.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic             overflow
);

  localparam int              IW      = idx_width(WIDTH);
  localparam logic [IW-1:0]   LP_LAST = IW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_mode;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_cin_eff;
  logic             w_fa_b;
  logic             w_fa_s;
  logic             w_fa_co;
  logic [WIDTH-1:0] w_acc_nxt;

  // A new operation may begin from IDLE or straight out of DONE
  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_idx == LP_LAST);
  assign w_cin_eff = (sub == SUB) ? 1'b1 : C_in;

  // B is stored as given; subtraction inverts it bit by bit at the cell
  assign w_fa_b = r_b[0] ^ (r_mode == SUB);

  full_adder u_fa (
    .A     (r_a[0]),
    .B     (w_fa_b),
    .C_in  (r_carry),
    .Sum   (w_fa_s),
    .C_out (w_fa_co)
  );

  // New sum bit enters at the MSB so the result ends LSB-aligned
  if (WIDTH == 1) begin : g_acc_w1
    assign w_acc_nxt = w_fa_s;
  end else begin : g_acc_wn
    assign w_acc_nxt = {w_fa_s, r_acc[WIDTH-1:1]};
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, serial add and result publish
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_mode  <= ADD;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_mode  <= sub;
      r_carry <= w_cin_eff;
      r_idx   <= '0;
      r_acc   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_fa_co;
      r_acc   <= w_acc_nxt;
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_fa_co;
        // r_carry is the carry into the MSB at this point
        r_ovf  <= r_carry ^ w_fa_co;
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign Sum      = r_sum;
  assign C_out    = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): arithmetic reference model with a
// per-cycle compare process, directed literal cases, randomized traffic.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         C_in = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, C_out, overflow;
  logic [W-1:0] Sum;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C_in(C_in),
    .sub(sub), .busy(busy), .done(done), .Sum(Sum), .C_out(C_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // {overflow, C_out, Sum} from plain arithmetic
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] a, b,
                                               input logic ci, sb);
    logic [W-1:0] be;
    logic         c0;
    logic [W:0]   t;
    logic         ov;
    be = sb ? ~b : b;
    c0 = sb ? 1'b1 : ci;
    t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
    ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction

  // Reference model: m_phase 0 idle, 1 computing (m_left edges to go), 2 result cycle
  int            m_phase = 0;
  int            m_left  = 0;
  int            m_ndone = 0;
  logic [W+1:0]  m_pend  = '0;
  logic [W+1:0]  m_vis   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_vis   = '0;
    end else if (m_phase == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_phase = 2;
        m_vis   = m_pend;
        m_ndone = m_ndone + 1;
      end
    end else if (start) begin
      m_pend  = ref_result(A, B, C_in, sub);
      m_left  = W;
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
  end

  int dut_ndone = 0;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (busy !== (m_phase == 1) || done !== (m_phase == 2)) begin
        fails++;
        $display("FAIL ctrl t=%0t busy=%b done=%b required busy=%b done=%b",
                 $time, busy, done, m_phase == 1, m_phase == 2);
      end
      if (m_phase != 1) begin
        tests++;
        if ({overflow, C_out, Sum} !== m_vis) begin
          fails++;
          $display("FAIL result t=%0t got ov=%b co=%b sum=%h required ov=%b co=%b sum=%h",
                   $time, overflow, C_out, Sum, m_vis[W+1], m_vis[W], m_vis[W-1:0]);
        end
      end
      if (done === 1'b1) dut_ndone++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic s, input logic [W-1:0] a, b,
                       input logic ci, sb);
    start = s; A = a; B = b; C_in = ci; sub = sb;
  endtask

  task automatic junk();
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Counts negedges until done is seen (20 means never seen)
  task automatic wait_done(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
      else n++;
    end
  endtask

  task automatic op_check(input string name, input logic [W-1:0] a, b,
                          input logic ci, sb, input logic [W-1:0] es,
                          input logic eco, eov);
    int n;
    drive(1'b1, a, b, ci, sb);
    tick();
    junk();
    wait_done(n);
    check({name, "_latency"}, 64'(n), 64'd8);
    check({name, "_sum"}, 64'(Sum), 64'(es));
    check({name, "_cout"}, 64'(C_out), 64'(eco));
    check({name, "_ovf"}, 64'(overflow), 64'(eov));
    tick();
  endtask

  initial begin
    int n;
    int cnt;
    logic [W-1:0] s1;

    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum", 64'(Sum), 64'd0);
    check("reset_cout_ovf", 64'({C_out, overflow}), 64'd0);

    op_check("add", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
    op_check("wrap1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op_check("wrap2", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op_check("sub1", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    op_check("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op_check("add_cin", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);

    // Results hold while idle
    tick(); tick(); tick();
    @(negedge clk);
    check("hold_sum", 64'(Sum), 64'h80);

    // Start while busy is ignored
    tick();
    drive(1'b1, 8'h21, 8'h12, 1'b0, 1'b0);
    tick();
    junk();
    tick(); tick();
    drive(1'b1, 8'hEE, 8'hEE, 1'b1, 1'b0);
    tick();
    junk();
    cnt = 0;
    s1 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cnt++;
        s1 = Sum;
      end
    end
    check("busy_start_dones", 64'(cnt), 64'd1);
    check("busy_start_sum", 64'(s1), 64'h33);

    // Reset four cycles into RUN
    tick();
    drive(1'b1, 8'h44, 8'h11, 1'b0, 1'b0);
    tick();
    junk();
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(Sum), 64'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    check("abort_no_done", 64'(cnt), 64'd0);
    tick();
    op_check("after_abort", 8'h44, 8'h11, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);

    // Back-to-back: start held through DONE
    drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h30, 8'h40, 1'b0, 1'b1);
    wait_done(n);
    check("b2b_first_latency", 64'(n), 64'd8);
    check("b2b_first_sum", 64'(Sum), 64'h03);
    check("b2b_done_busy", 64'(busy), 64'd0);
    tick();
    junk();
    wait_done(n);
    check("b2b_gap", 64'(n + 1), 64'd9);
    check("b2b_second_sum", 64'({C_out, Sum}), 64'h0F0);
    tick();

    // Randomized traffic, including rare resets and starts while busy
    dut_ndone = 0;
    m_ndone = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 2) == 0), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b0;
    junk();
    repeat (12) tick();
    @(negedge clk);
    check("rand_done_count", 64'(dut_ndone), 64'(m_ndone));
    check("rand_activity", 64'(m_ndone > 50), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
